// File: rtl/sprite_line_sequencer_pkg.sv
`default_nettype none
// =====================================================================
// sprite_pkg : shared constants and types for the sprite line sequencer
// Rev 1.0
// =====================================================================
package sprite_pkg;

   localparam int NUM_SPRITES = 4;
   localparam int SPRITE_W    = 16;
   localparam int SPRITE_H    = 16;
   localparam int H_ACTIVE    = 640;
   localparam int ROW_W       = $clog2(SPRITE_H);
   localparam int CNT_W       = $clog2(SPRITE_W + 1);

   typedef logic [2*SPRITE_W-1:0] row_word_t;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CHECK = 3'd1,
      ST_READ  = 3'd2,
      ST_WAIT  = 3'd3,
      ST_STORE = 3'd4,
      ST_DONE  = 3'd5
   } fetch_state_t;

   typedef struct packed {
      logic       on;
      logic [9:0] x;
      logic [9:0] y;
      logic [3:0] frame;
   } sprite_attr_t;

endpackage
`default_nettype wire

// File: rtl/sprite_line_sequencer_if.sv
`default_nettype none
// =====================================================================
// sprite_line_sequencer_if : sprite ROM read port (sequencer = master)
// Rev 1.0
// =====================================================================
interface sprite_line_sequencer_if
   import sprite_pkg::*;
#(
   parameter int ROM_AW = 10
);
   logic              rom_rd;
   logic [ROM_AW-1:0] rom_addr;
   row_word_t         rom_data;

   modport master (output rom_rd, output rom_addr, input rom_data);
   modport slave  (input rom_rd, input rom_addr, output rom_data);
endinterface
`default_nettype wire

// File: rtl/sprite_line_sequencer_draw_ctr.sv
`default_nettype none
// =====================================================================
// sprite_draw_ctr : per-sprite pixel counter driving one shifter's ld/en
// Rev 1.0
// =====================================================================
module sprite_draw_ctr
   import sprite_pkg::*;
(
   input  wire logic                  clk,
   input  wire logic                  rst,
   input  wire logic                  i_px_tick,
   input  wire logic [10:0]           i_hcount,
   input  wire logic [9:0]            i_x,
   input  wire logic                  i_valid,
   input  wire logic [2*SPRITE_W-1:0] i_word,
   output logic                       o_ld,
   output logic                       o_en,
   output logic [2*SPRITE_W-1:0]      o_data
);

   logic [CNT_W-1:0] r_cnt;
   row_word_t        r_data;
   logic             w_start;
   logic             w_shift;

   // A start is only honoured with an idle counter, so an overlapping start is dropped.
   assign w_start = i_px_tick && !rst && (i_hcount < 11'(H_ACTIVE)) &&
                    (i_hcount == {1'b0, i_x}) && i_valid && (r_cnt == '0);
   assign w_shift = i_px_tick && !rst && (r_cnt != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt  <= '0;
         r_data <= '0;
      end else if (w_start) begin
         r_cnt  <= CNT_W'(SPRITE_W);
         r_data <= i_word;
      end else if (w_shift) begin
         r_cnt  <= r_cnt - 1'b1;
      end
   end

   assign o_ld   = w_start;
   assign o_en   = w_shift;
   assign o_data = w_start ? i_word : r_data;

endmodule
`default_nettype wire

// File: rtl/sprite_line_sequencer.sv
`default_nettype none
// =====================================================================
// sprite_line_sequencer : hblank row fetch + double line buffer + draw timing
// Rev 1.0
// =====================================================================
module sprite_line_sequencer
   import sprite_pkg::*;
#(
   parameter int ROM_AW  = 10,
   parameter int ROM_LAT = 1
)(
   input  wire logic                                   clk,
   input  wire logic                                   reset,
   input  wire logic                                   px_tick,
   input  wire logic [10:0]                            hcount,
   input  wire logic [9:0]                             vcount,
   input  wire logic [NUM_SPRITES-1:0]                 spr_on,
   input  wire logic [NUM_SPRITES-1:0][9:0]            spr_x,
   input  wire logic [NUM_SPRITES-1:0][9:0]            spr_y,
   input  wire logic [NUM_SPRITES-1:0][3:0]            spr_frame,
   sprite_line_sequencer_if.master                     rom,
   output logic      [NUM_SPRITES-1:0]                 sh_ld,
   output logic      [NUM_SPRITES-1:0]                 sh_en,
   output logic      [NUM_SPRITES-1:0][2*SPRITE_W-1:0] sh_data,
   output logic                                        busy,
   output logic                                        overrun
);

   localparam int               IDX_W       = $clog2(NUM_SPRITES);
   localparam logic [IDX_W-1:0] c_LAST_IDX  = IDX_W'(NUM_SPRITES - 1);
   localparam logic [7:0]       c_WAIT_LAST = 8'((ROM_LAT > 1) ? (ROM_LAT - 2) : 0);

   fetch_state_t                      r_state;
   logic [IDX_W-1:0]                  r_idx;
   logic [9:0]                        r_tl;
   logic [7:0]                        r_wait;
   logic                              r_rom_rd;
   logic [ROM_AW-1:0]                 r_rom_addr;
   row_word_t [NUM_SPRITES-1:0]       r_pend_word;
   row_word_t [NUM_SPRITES-1:0]       r_act_word;
   logic [NUM_SPRITES-1:0]            r_pend_vld;
   logic [NUM_SPRITES-1:0]            r_act_vld;
   logic                              r_overrun;

   sprite_attr_t                      w_attr [NUM_SPRITES];
   logic [9:0]                        w_row;
   logic                              w_hit;
   logic [ROM_AW-1:0]                 w_addr;
   logic                              w_swap;
   logic                              w_trig;
   logic                              w_late;
   logic [NUM_SPRITES-1:0]            w_fetched;

   for (genvar gi = 0; gi < NUM_SPRITES; gi++) begin : g_attr
      assign w_attr[gi] = '{on: spr_on[gi], x: spr_x[gi], y: spr_y[gi], frame: spr_frame[gi]};
   end

   // 10-bit unsigned subtraction: sprites near y=1023 wrap onto the top lines.
   assign w_row  = r_tl - w_attr[r_idx].y;
   assign w_hit  = w_attr[r_idx].on && (w_row < 10'(SPRITE_H));
   assign w_addr = ROM_AW'(w_attr[r_idx].frame) * ROM_AW'(SPRITE_H) + ROM_AW'(w_row[ROW_W-1:0]);
   assign w_swap = px_tick && (hcount == 11'd0);
   assign w_trig = px_tick && (hcount == 11'(H_ACTIVE));
   assign w_late = (r_state != ST_IDLE) && (r_state != ST_DONE);

   // Sprites below the current index have fresh pending entries for this line.
   always_comb begin
      w_fetched = '0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
         w_fetched[i] = (IDX_W'(i) < r_idx);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_idx       <= '0;
         r_tl        <= '0;
         r_wait      <= '0;
         r_rom_rd    <= 1'b0;
         r_rom_addr  <= '0;
         r_pend_word <= '0;
         r_act_word  <= '0;
         r_pend_vld  <= '0;
         r_act_vld   <= '0;
         r_overrun   <= 1'b0;
      end else begin
         r_rom_rd <= 1'b0;

         if (w_swap) begin
            r_act_word <= r_pend_word;
            r_act_vld  <= w_late ? (r_pend_vld & w_fetched) : r_pend_vld;
            if (w_late) begin
               r_overrun <= 1'b1;
               r_state   <= ST_IDLE;
            end
         end

         if (!(w_swap && w_late)) begin
            unique case (r_state)
               ST_IDLE: begin
                  if (w_trig) begin
                     r_state <= ST_CHECK;
                     r_idx   <= '0;
                     r_tl    <= vcount + 10'd1;
                  end
               end
               ST_CHECK: begin
                  if (w_hit) begin
                     r_state    <= ST_READ;
                     r_rom_rd   <= 1'b1;
                     r_rom_addr <= w_addr;
                  end else begin
                     r_pend_vld[r_idx] <= 1'b0;
                     if (r_idx == c_LAST_IDX) begin
                        r_state <= ST_DONE;
                     end else begin
                        r_idx   <= r_idx + 1'b1;
                        r_state <= ST_CHECK;
                     end
                  end
               end
               ST_READ: begin
                  r_wait  <= '0;
                  r_state <= (ROM_LAT == 1) ? ST_STORE : ST_WAIT;
               end
               ST_WAIT: begin
                  if (r_wait == c_WAIT_LAST) begin
                     r_state <= ST_STORE;
                  end else begin
                     r_wait <= r_wait + 8'd1;
                  end
               end
               ST_STORE: begin
                  r_pend_word[r_idx] <= rom.rom_data;
                  r_pend_vld[r_idx]  <= 1'b1;
                  if (r_idx == c_LAST_IDX) begin
                     r_state <= ST_DONE;
                  end else begin
                     r_idx   <= r_idx + 1'b1;
                     r_state <= ST_CHECK;
                  end
               end
               ST_DONE: begin
                  if (w_swap) begin
                     r_state <= ST_IDLE;
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   for (genvar gi = 0; gi < NUM_SPRITES; gi++) begin : g_draw
      sprite_draw_ctr u_draw (
         .clk       (clk),
         .rst       (reset),
         .i_px_tick (px_tick),
         .i_hcount  (hcount),
         .i_x       (w_attr[gi].x),
         .i_valid   (r_act_vld[gi]),
         .i_word    (r_act_word[gi]),
         .o_ld      (sh_ld[gi]),
         .o_en      (sh_en[gi]),
         .o_data    (sh_data[gi])
      );
   end

   assign rom.rom_rd   = r_rom_rd;
   assign rom.rom_addr = r_rom_addr;
   assign busy         = (r_state != ST_IDLE);
   assign overrun      = r_overrun;

endmodule
`default_nettype wire
